// File: rtl/ac97_frame_tx.sv
// AC97 output frame serializer: builds the 256-bit tag/command/PCM frame once per frame
// and shifts it out MSB first on SDATA_OUT with SYNC, all in the BIT_CLK domain.
module ac97_frame_tx #(
  parameter int unsigned N_CH          = 2,
  parameter int unsigned SAMPLE_W      = 16,
  parameter int unsigned UNDERRUN_ZERO = 0
) (
  input  logic                     BIT_CLK,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_CH*SAMPLE_W-1:0] smp_data,
  input  logic                     smp_valid,
  output logic                     smp_ready,
  input  logic                     cmd_valid,
  input  logic                     cmd_rd,
  input  logic [6:0]               cmd_addr,
  input  logic [15:0]              cmd_data,
  output logic                     cmd_ready,
  output logic                     SYNC,
  output logic                     SDATA_OUT,
  output logic                     frame_start,
  output logic                     underrun
);

  localparam int unsigned SmpW = N_CH * SAMPLE_W;

  logic [7:0]      cnt_q;
  logic [255:0]    frm_q, frm_d;
  logic [SmpW-1:0] last_q;
  logic [SmpW-1:0] pcm;
  logic            load, smp_xfer, cmd_xfer, pcm_on;

  // PCM channel index to AC97 slot number (slot 5 is skipped).
  function automatic int unsigned ch_slot(input int unsigned ch);
    case (ch)
      0:       ch_slot = 3;
      1:       ch_slot = 4;
      2:       ch_slot = 6;
      3:       ch_slot = 7;
      4:       ch_slot = 8;
      default: ch_slot = 9;
    endcase
  endfunction

  assign load      = (cnt_q == 8'd255);
  assign smp_ready = load && enable;
  assign cmd_ready = load && enable;
  assign smp_xfer  = smp_valid && smp_ready;
  assign cmd_xfer  = cmd_valid && cmd_ready;
  assign pcm       = smp_xfer ? smp_data : last_q;
  assign pcm_on    = enable && (smp_xfer || (UNDERRUN_ZERO == 0));

  // Slot s (1..12) starts at frame bit 259-20*s; its tag flag sits at frame bit 255-s.
  always_comb begin
    frm_d      = '0;
    frm_d[255] = enable;
    if (cmd_xfer) begin
      frm_d[254]     = 1'b1;
      frm_d[239]     = cmd_rd;
      frm_d[238:232] = cmd_addr;
      if (!cmd_rd) begin
        frm_d[253]     = 1'b1;
        frm_d[219:204] = cmd_data;
      end
    end
    if (pcm_on) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        frm_d[255 - ch_slot(i)]                    = 1'b1;
        frm_d[259 - 20*ch_slot(i) -: SAMPLE_W]     = pcm[i*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  always_ff @(posedge BIT_CLK or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      frm_q       <= '0;
      last_q      <= '0;
      SYNC        <= 1'b0;
      SDATA_OUT   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cnt_q       <= cnt_q + 8'd1;
      SDATA_OUT   <= frm_q[~cnt_q];
      SYNC        <= (cnt_q < 8'd16);
      frame_start <= (cnt_q == 8'd0);
      underrun    <= load && enable && !smp_valid;
      if (load) begin
        frm_q <= frm_d;
        if (smp_xfer) last_q <= smp_data;
      end
    end
  end

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Scoreboard bench for ac97_frame_tx: one 2ch/16-bit repeat-on-underrun instance and one
// 6ch/20-bit zero-on-underrun instance; serialized frames are captured and checked whole.
module tb_ac97_frame_tx;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         en_a = 1'b0, sv_a = 1'b0, cv_a = 1'b0, rd_a = 1'b0;
  logic [31:0]  smp_a = '0;
  logic [6:0]   addr_a = '0;
  logic [15:0]  data_a = '0;
  logic         sr_a, cr_a, sync_a, sd_a, fs_a, unr_a;

  logic         en_b = 1'b0, sv_b = 1'b0, cv_b = 1'b0, rd_b = 1'b0;
  logic [119:0] smp_b = '0;
  logic [6:0]   addr_b = '0;
  logic [15:0]  data_b = '0;
  logic         sr_b, cr_b, sync_b, sd_b, fs_b, unr_b;

  ac97_frame_tx #(.N_CH(2), .SAMPLE_W(16), .UNDERRUN_ZERO(0)) dut_a (
    .BIT_CLK(clk), .reset(reset), .enable(en_a), .smp_data(smp_a), .smp_valid(sv_a),
    .smp_ready(sr_a), .cmd_valid(cv_a), .cmd_rd(rd_a), .cmd_addr(addr_a), .cmd_data(data_a),
    .cmd_ready(cr_a), .SYNC(sync_a), .SDATA_OUT(sd_a), .frame_start(fs_a), .underrun(unr_a)
  );

  ac97_frame_tx #(.N_CH(6), .SAMPLE_W(20), .UNDERRUN_ZERO(1)) dut_b (
    .BIT_CLK(clk), .reset(reset), .enable(en_b), .smp_data(smp_b), .smp_valid(sv_b),
    .smp_ready(sr_b), .cmd_valid(cv_b), .cmd_rd(rd_b), .cmd_addr(addr_b), .cmd_data(data_b),
    .cmd_ready(cr_b), .SYNC(sync_b), .SDATA_OUT(sd_b), .frame_start(fs_b), .underrun(unr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   tb_cnt = '0;
  logic [255:0] exp_a = '0, exp_b = '0;
  logic [255:0] qa[$];
  logic [255:0] qb[$];
  logic [255:0] sh_a = '0, sh_b = '0;
  int           nb_a = 0, nb_b = 0;
  logic         act_a = 1'b0, act_b = 1'b0;

  localparam logic [119:0] PB = {20'h80001, 20'hFFFFF, 20'h0A5A5, 20'hF0F0F, 20'hABCDE,
                                 20'h12345};

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  function automatic logic [255:0] mk(input logic [15:0] tag, input logic [19:0] s1,
                                      input logic [19:0] s2, input logic [19:0] s3,
                                      input logic [19:0] s4, input logic [19:0] s6,
                                      input logic [19:0] s7, input logic [19:0] s8,
                                      input logic [19:0] s9);
    return {tag, s1, s2, s3, s4, 20'h0, s6, s7, s8, s9, 60'h0};
  endfunction

  // Reference frame position; expectations are queued at each load edge.
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cnt <= '0;
    else       tb_cnt <= tb_cnt + 8'd1;
  end

  always @(posedge clk) begin
    if (!reset && tb_cnt == 8'd255) begin
      qa.push_back(exp_a);
      qb.push_back(exp_b);
    end
  end

  always @(negedge clk) begin
    if (reset) act_a = 1'b0;
    else begin
      if (fs_a) begin act_a = 1'b1; nb_a = 0; end
      if (act_a) begin
        sh_a = {sh_a[254:0], sd_a};
        nb_a++;
        if (nb_a == 256) begin
          act_a = 1'b0;
          if (qa.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_a: got %h, required <none queued>", sh_a);
          end else chk("frame_a", sh_a, qa.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) act_b = 1'b0;
    else begin
      if (fs_b) begin act_b = 1'b1; nb_b = 0; end
      if (act_b) begin
        sh_b = {sh_b[254:0], sd_b};
        nb_b++;
        if (nb_b == 256) begin
          act_b = 1'b0;
          if (qb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_b: got %h, required <none queued>", sh_b);
          end else chk("frame_b", sh_b, qb.pop_front());
        end
      end
    end
  end

  task automatic drive(input int k, input logic en, input logic sv, input logic [119:0] smp,
                       input logic cv, input logic rd, input logic [6:0] addr,
                       input logic [15:0] data);
    if (k == 0) begin
      en_a = en; sv_a = sv; smp_a = smp[31:0]; cv_a = cv; rd_a = rd; addr_a = addr;
      data_a = data;
    end else begin
      en_b = en; sv_b = sv; smp_b = smp; cv_b = cv; rd_b = rd; addr_b = addr; data_b = data;
    end
  endtask

  // One load edge: present inputs from cnt 250, check the handshake window, queue the frame.
  task automatic frame(input int k, input logic en, input logic sv, input logic [119:0] smp,
                       input logic cv, input logic rd, input logic [6:0] addr,
                       input logic [15:0] data, input logic [255:0] want, input logic unr);
    do @(negedge clk); while (tb_cnt != 8'd250);
    drive(k, en, sv, smp, cv, rd, addr, data);
    for (int j = 0; j < 5; j++) begin
      chk("ready_early", (k == 0) ? {sr_a, cr_a} : {sr_b, cr_b}, 2'b00);
      @(negedge clk);
    end
    chk("ready_load", (k == 0) ? {sr_a, cr_a} : {sr_b, cr_b}, {en, en});
    if (k == 0) exp_a = want;
    else        exp_b = want;
    @(posedge clk);
    @(negedge clk);
    chk("underrun_pulse", (k == 0) ? unr_a : unr_b, unr);
    drive(k, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    if (k == 0) exp_a = '0;
    else        exp_b = '0;
    @(negedge clk);
    chk("underrun_clear", (k == 0) ? unr_a : unr_b, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_a", {sync_a, sd_a, fs_a, unr_a}, 4'b0000);
    chk("rst_out_b", {sync_b, sd_b, fs_b, unr_b}, 4'b0000);
    qa.delete();
    qb.delete();
    exp_a = '0;
    exp_b = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    qa.push_back('0);
    qb.push_back('0);
    @(negedge clk);
    chk("first_edge_a", {sync_a, fs_a}, 2'b11);
    chk("first_edge_b", {sync_b, fs_b}, 2'b11);
  endtask

  task automatic reset_at(input logic [7:0] c);
    do @(negedge clk); while (tb_cnt != c);
    do_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sync_hi, sd_ones, unr_ones, fs_n, fs_first, fs_gap;
    #2;
    do_reset();

    // Link disabled: SYNC cadence only, no data, no underrun.
    sync_hi = 0; sd_ones = 0; unr_ones = 0; fs_n = 0; fs_first = -1; fs_gap = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      sync_hi  += int'(sync_a);
      sd_ones  += int'(sd_a) + int'(sd_b);
      unr_ones += int'(unr_a) + int'(unr_b);
      if (fs_a) begin
        fs_n++;
        if (fs_first < 0) fs_first = i;
        else              fs_gap = i - fs_first;
      end
    end
    chk("sync_high_count", 256'(sync_hi), 256'(32));
    chk("sdata_idle", 256'(sd_ones), 256'(0));
    chk("underrun_idle", 256'(unr_ones), 256'(0));
    chk("frame_start_count", 256'(fs_n), 256'(2));
    chk("frame_start_period", 256'(fs_gap), 256'(256));

    // Two-channel 16-bit instance.
    frame(0, 1, 1, 120'h8001_1234, 0, 0, 7'h00, 16'h0000,
          mk(16'h9800, 0, 0, 20'h12340, 20'h80010, 0, 0, 0, 0), 0);
    frame(0, 1, 1, 120'hBEEF_0102, 1, 0, 7'h02, 16'h0808,
          mk(16'hF800, 20'h02000, 20'h08080, 20'h01020, 20'hBEEF0, 0, 0, 0, 0), 0);
    frame(0, 1, 1, 120'h00FF_7F00, 1, 1, 7'h26, 16'hFFFF,
          mk(16'hD800, 20'hA6000, 0, 20'h7F000, 20'h00FF0, 0, 0, 0, 0), 0);
    frame(0, 1, 0, 120'h0, 0, 0, 7'h00, 16'h0000,
          mk(16'h9800, 0, 0, 20'h7F000, 20'h00FF0, 0, 0, 0, 0), 1);
    frame(0, 1, 0, 120'h1111_2222, 0, 0, 7'h00, 16'h0000,
          mk(16'h9800, 0, 0, 20'h7F000, 20'h00FF0, 0, 0, 0, 0), 1);
    frame(0, 0, 1, 120'h1111_2222, 1, 0, 7'h05, 16'h1234, '0, 0);
    frame(0, 1, 0, 120'h0, 0, 0, 7'h00, 16'h0000,
          mk(16'h9800, 0, 0, 20'h7F000, 20'h00FF0, 0, 0, 0, 0), 1);

    // Six-channel 20-bit instance, zeros on underrun.
    frame(1, 1, 1, PB, 0, 0, 7'h00, 16'h0000,
          mk(16'h9BC0, 0, 0, 20'h12345, 20'hABCDE, 20'hF0F0F, 20'h0A5A5, 20'hFFFFF, 20'h80001),
          0);
    frame(1, 1, 0, PB, 0, 0, 7'h00, 16'h0000, mk(16'h8000, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    frame(1, 1, 1, PB, 1, 0, 7'h7F, 16'hA5A5,
          mk(16'hFBC0, 20'h7F000, 20'hA5A50, 20'h12345, 20'hABCDE, 20'hF0F0F, 20'h0A5A5,
             20'hFFFFF, 20'h80001), 0);

    // Abandon frames mid-flight: once while SYNC/SDATA are high, once mid-frame.
    reset_at(8'd8);
    frame(1, 1, 1, PB, 0, 0, 7'h00, 16'h0000,
          mk(16'h9BC0, 0, 0, 20'h12345, 20'hABCDE, 20'hF0F0F, 20'h0A5A5, 20'hFFFFF, 20'h80001),
          0);
    reset_at(8'd100);

    for (int i = 0; i < 300; i++) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
